// File: rtl/psum_pkg.sv
// Shared constants and FSM state type for the psum accumulation buffer.
// FIFO_LEAD/ADD_LAT must match the adder wrapper's pipeline timing.
package psum_pkg;
   localparam int PSUM_DATA_WIDTH = 25;
   localparam int PSUM_FIFO_LEAD  = 2;
   localparam int PSUM_ADD_LAT    = 3;

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
endpackage

// File: rtl/psum_sdp_ram.sv
// Simple dual-port psum storage: one write port, one synchronous read port.
// A read and a write to the same address on the same edge return the old data.
module psum_sdp_ram
   import psum_pkg::*;
#(
   parameter int DATA_WIDTH = PSUM_DATA_WIDTH,
   parameter int DEPTH      = 64,
   parameter int ADDR_W     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  re,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
      if (re) rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/psum_acc_buf.sv
// Partial-sum accumulation buffer: feeds stored psums to the adder, captures results,
// then drains finished sums over valid/ready. Define PSUM_RELU_EN to clamp negative drained sums.
module psum_acc_buf
   import psum_pkg::*;
#(
   parameter int DATA_WIDTH = PSUM_DATA_WIDTH,
   parameter int DEPTH      = 64,
   parameter int ADDR_W     = $clog2(DEPTH),
   parameter int FIFO_LEAD  = PSUM_FIFO_LEAD,
   parameter int ADD_LAT    = PSUM_ADD_LAT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_W:0]       cfg_len,
   input  logic [7:0]            cfg_passes,
   input  logic                  pe_valid,
   output logic [DATA_WIDTH-1:0] fifo_data,
   input  logic [DATA_WIDTH-1:0] psum_in,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);
   localparam int LW    = ADDR_W + 1;
   localparam int CNT_W = ADDR_W + 9;

   state_t                state;
   logic [LW-1:0]         len_q, len_m1;
   logic [7:0]            passes_q, pass_cnt;
   logic [CNT_W-1:0]      beat_cnt, beat_total;
   logic [ADD_LAT:1]      vld_d;
   logic [ADDR_W-1:0]     rd_addr_acc, wr_addr, ram_rd_addr;
   logic                  rd_first, rd_first_q;
   logic                  byp_q;
   logic [DATA_WIDTH-1:0] byp_data, ram_q, sk_data, drain_word;
   logic [LW-1:0]         dr_issue, dr_pop;
   logic                  dr_inflight, sk_vld;
   logic [1:0]            occ;
   logic                  cfg_ok, beat_ok, rd_issue, rd_en, wr_en, last_wr, pop, dr_req, ram_re, head_hold;

   function automatic logic [DATA_WIDTH-1:0] drain_fmt(input logic [DATA_WIDTH-1:0] v);
`ifdef PSUM_RELU_EN
      return v[DATA_WIDTH-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   assign len_m1     = len_q - LW'(1);
   assign beat_total = CNT_W'(len_q) * CNT_W'(passes_q);
   assign cfg_ok     = (cfg_len >= LW'(2)) && (cfg_len <= LW'(DEPTH)) && (cfg_passes != 8'd0);
   assign beat_ok    = pe_valid && (state == ACCUM) && (beat_cnt < beat_total);
   assign rd_issue   = vld_d[FIFO_LEAD-1];
   assign rd_en      = vld_d[FIFO_LEAD];
   assign wr_en      = vld_d[ADD_LAT];
   assign last_wr    = wr_en && ({1'b0, wr_addr} == len_m1) && (pass_cnt == passes_q - 8'd1);
   assign pop        = out_valid && out_ready;
   assign head_hold  = out_valid && !out_ready;
   assign occ        = {1'b0, out_valid} + {1'b0, sk_vld} + {1'b0, dr_inflight};
   // Only request a drain read when the skid can absorb it, counting the read already in flight.
   assign dr_req     = (state == DRAIN) && (dr_issue != len_q) && ((occ < 2'd2) || (occ == 2'd2 && pop));
   assign ram_re     = rd_issue || dr_req;
   assign ram_rd_addr = (state == DRAIN) ? dr_issue[ADDR_W-1:0] : rd_addr_acc;
   assign drain_word = drain_fmt(ram_q);
   assign busy       = (state != IDLE);
   assign fifo_data  = (rd_en && !rd_first_q) ? (byp_q ? byp_data : ram_q) : '0;

   psum_sdp_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
      .clk     (clk),
      .we      (wr_en),
      .wr_addr (wr_addr),
      .wr_data (psum_in),
      .re      (ram_re),
      .rd_addr (ram_rd_addr),
      .rd_data (ram_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         len_q       <= '0;
         passes_q    <= '0;
         pass_cnt    <= '0;
         beat_cnt    <= '0;
         vld_d       <= '0;
         rd_addr_acc <= '0;
         wr_addr     <= '0;
         rd_first    <= 1'b0;
         rd_first_q  <= 1'b0;
         byp_q       <= 1'b0;
         dr_issue    <= '0;
         dr_pop      <= '0;
         dr_inflight <= 1'b0;
         sk_vld      <= 1'b0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         done        <= 1'b0;
         vld_d       <= {vld_d[ADD_LAT-1:1], beat_ok};
         rd_first_q  <= rd_first;
         dr_inflight <= dr_req;
         // With cfg_len=2 the re-read of an entry lands on the same edge as its write.
         byp_q       <= rd_issue && wr_en && (rd_addr_acc == wr_addr);

         if (state == IDLE && start) err <= !cfg_ok || pe_valid;
         else if (pe_valid && !beat_ok) err <= 1'b1;

         case (state)
            IDLE: if (start && cfg_ok) begin
               state       <= ACCUM;
               len_q       <= cfg_len;
               passes_q    <= cfg_passes;
               pass_cnt    <= '0;
               beat_cnt    <= '0;
               rd_addr_acc <= '0;
               wr_addr     <= '0;
               rd_first    <= 1'b1;
            end
            ACCUM: begin
               beat_cnt <= beat_cnt + CNT_W'(beat_ok);
               if (rd_issue) begin
                  if ({1'b0, rd_addr_acc} == len_m1) begin
                     rd_addr_acc <= '0;
                     rd_first    <= 1'b0;
                  end else begin
                     rd_addr_acc <= rd_addr_acc + ADDR_W'(1);
                  end
               end
               if (wr_en) begin
                  if ({1'b0, wr_addr} == len_m1) begin
                     wr_addr  <= '0;
                     pass_cnt <= pass_cnt + 8'd1;
                  end else begin
                     wr_addr <= wr_addr + ADDR_W'(1);
                  end
               end
               if (last_wr) begin
                  state    <= DRAIN;
                  dr_issue <= '0;
                  dr_pop   <= '0;
               end
            end
            DRAIN: begin
               if (dr_req) dr_issue <= dr_issue + LW'(1);
               if (pop) begin
                  dr_pop <= dr_pop + LW'(1);
                  if (dr_pop == len_m1) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         // Two-entry output skid: out_data/out_valid is the head, sk_* the spare slot.
         if (!head_hold) begin
            if (sk_vld) begin
               out_data  <= sk_data;
               out_valid <= 1'b1;
               sk_vld    <= dr_inflight;
            end else if (dr_inflight) begin
               out_data  <= drain_word;
               out_valid <= 1'b1;
            end else begin
               out_valid <= 1'b0;
            end
         end else if (dr_inflight) begin
            sk_vld <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      byp_data <= psum_in;
      if (dr_inflight && (head_hold || sk_vld)) sk_data <= drain_word;
   end
endmodule
